// File: rtl/muldiv_pkg.sv
// Shared types for the EX-stage multiply/divide sequencer: op encoding seen by the id decoder,
// FSM state encoding, and default timing parameters.
package muldiv_pkg;

    localparam int unsigned MulLatDefault = 3;
    localparam int unsigned DivTmoDefault = 40;

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StMulWait,
        StDivWait,
        StDone
    } muldiv_state_t;

    function automatic logic is_mul(input muldiv_op_t op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic is_div(input muldiv_op_t op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic [31:0] hi_wdata,
    input  logic        lo_we,
    input  logic [31:0] lo_wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (hi_we) hi <= hi_wdata;
            if (lo_we) lo <= lo_wdata;
        end
    end

endmodule

// File: rtl/muldiv_sched.sv
// Multi-cycle MULT/DIV sequencer: issues to external multiplier/divider, stalls EX while busy,
// and is the sole writer of HI/LO (including MTHI/MTLO).
module muldiv_sched
    import muldiv_pkg::*;
#(
    parameter int unsigned MUL_LAT = MulLatDefault,
    parameter int unsigned DIV_TMO = DivTmoDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_stall,
    input  logic        reg_flush,
    output logic        alu_stall,
    input  muldiv_op_t  op,
    input  logic [31:0] source_a,
    input  logic [31:0] source_b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        mul_start,
    output logic        mul_sign,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_sign,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_cancel,
    input  logic        div_done,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem
);

    localparam int unsigned CntMax = (DIV_TMO > MUL_LAT) ? DIV_TMO : MUL_LAT;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    muldiv_state_t   state;
    logic [CntW-1:0] cnt;
    logic            mul_sign_q, div_sign_q;
    logic [31:0]     mul_a_q, mul_b_q, div_a_q, div_b_q;

    logic        issue_mul, issue_div;
    logic        hi_we, lo_we;
    logic [31:0] hi_wdata, lo_wdata;

    always_comb begin
        issue_mul = (state == StIdle) && !reg_flush && is_mul(op);
        issue_div = (state == StIdle) && !reg_flush && is_div(op) && (source_b != '0);

        // Start pulses fire in the issue cycle so the unit sees operands MUL_LAT cycles before
        // the sample point; operands are bypassed from the inputs until the latch takes over.
        mul_start = issue_mul;
        mul_sign  = issue_mul ? (op == OpMult) : mul_sign_q;
        mul_a     = issue_mul ? source_a : mul_a_q;
        mul_b     = issue_mul ? source_b : mul_b_q;
        div_start = issue_div;
        div_sign  = issue_div ? (op == OpDiv) : div_sign_q;
        div_a     = issue_div ? source_a : div_a_q;
        div_b     = issue_div ? source_b : div_b_q;

        div_cancel = (state == StDivWait) && (reg_flush || (!div_done && (cnt == '0)));
        alu_stall  = issue_mul || issue_div || (state == StMulWait) || (state == StDivWait);

        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = source_a;
        lo_wdata = source_a;
        if (!reg_flush) begin
            case (state)
                StIdle: begin
                    if (!reg_stall) begin
                        hi_we = (op == OpMthi);
                        lo_we = (op == OpMtlo);
                    end
                end
                StMulWait: begin
                    if (cnt == '0) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_wdata = mul_result[63:32];
                        lo_wdata = mul_result[31:0];
                    end
                end
                StDivWait: begin
                    if (div_done) begin
                        hi_we    = 1'b1;
                        lo_we    = 1'b1;
                        hi_wdata = div_rem;
                        lo_wdata = div_quot;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= StIdle;
            cnt        <= '0;
            mul_sign_q <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            div_sign_q <= 1'b0;
            div_a_q    <= '0;
            div_b_q    <= '0;
        end else if (reg_flush) begin
            state <= StIdle;
            cnt   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (issue_mul) begin
                        state      <= StMulWait;
                        cnt        <= CntW'(MUL_LAT - 1);
                        mul_sign_q <= (op == OpMult);
                        mul_a_q    <= source_a;
                        mul_b_q    <= source_b;
                    end else if (issue_div) begin
                        state      <= StDivWait;
                        cnt        <= CntW'(DIV_TMO);
                        div_sign_q <= (op == OpDiv);
                        div_a_q    <= source_a;
                        div_b_q    <= source_b;
                    end
                end
                StMulWait: begin
                    if (cnt == '0) state <= StDone;
                    else           cnt   <= cnt - CntW'(1);
                end
                StDivWait: begin
                    // Watchdog expiry and normal completion both land in DONE; only done writes HI/LO.
                    if (div_done || (cnt == '0)) state <= StDone;
                    else                         cnt   <= cnt - CntW'(1);
                end
                StDone: begin
                    if (!reg_stall) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    hilo_reg u_hilo_reg (
        .clk      (clk),
        .rst      (rst),
        .hi_we    (hi_we),
        .hi_wdata (hi_wdata),
        .lo_we    (lo_we),
        .lo_wdata (lo_wdata),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: pipelined multiplier model, hand-driven divider responses.
module tb_muldiv_sched;
    import muldiv_pkg::*;

    localparam int unsigned MulLat = 3;
    localparam int unsigned DivTmo = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_stall, reg_flush, alu_stall;
    muldiv_op_t  op;
    logic [31:0] source_a, source_b, hi, lo;
    logic        mul_start, mul_sign;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_result;
    logic        div_start, div_sign, div_cancel, div_done;
    logic [31:0] div_a, div_b, div_quot, div_rem;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_sched #(
        .MUL_LAT (MulLat),
        .DIV_TMO (DivTmo)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_stall  (reg_stall),
        .reg_flush  (reg_flush),
        .alu_stall  (alu_stall),
        .op         (op),
        .source_a   (source_a),
        .source_b   (source_b),
        .hi         (hi),
        .lo         (lo),
        .mul_start  (mul_start),
        .mul_sign   (mul_sign),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_sign   (div_sign),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_cancel (div_cancel),
        .div_done   (div_done),
        .div_quot   (div_quot),
        .div_rem    (div_rem)
    );

    // Result is only meaningful exactly MulLat cycles after a start; otherwise a poison value.
    logic [63:0] prod;
    logic [63:0] mul_pipe [MulLat];
    always_comb begin
        if (mul_sign) prod = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
        else          prod = {32'b0, mul_a} * {32'b0, mul_b};
    end
    always_ff @(posedge clk) begin
        mul_pipe[0] <= mul_start ? prod : 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 1; i < MulLat; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign mul_result = mul_pipe[MulLat-1];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; holds op until alu_stall drops (bounded).
    task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                          input int done_at, output int stall_n, output int mstart_n,
                          output int dstart_n, output int cancel_n, output int cancel_k,
                          output logic sign0);
        stall_n = 0; mstart_n = 0; dstart_n = 0; cancel_n = 0; cancel_k = -1; sign0 = 1'b0;
        op = o; source_a = a; source_b = b;
        for (int k = 0; k < 100; k++) begin
            div_done = (k == done_at);
            #1;
            if (k == 0) sign0 = mul_start ? mul_sign : div_sign;
            if (alu_stall) stall_n++;
            if (mul_start) mstart_n++;
            if (div_start) dstart_n++;
            if (div_cancel) begin
                cancel_n++;
                cancel_k = k;
            end
            if (!alu_stall) begin
                op = OpNone;
                break;
            end
            @(posedge clk);
            #1;
        end
        div_done = 1'b0;
    endtask

    initial begin
        int   st, ms, ds, cn, ck, acc;
        logic sg;
        rst = 1'b0; op = OpNone; source_a = '0; source_b = '0;
        reg_stall = 1'b0; reg_flush = 1'b0; div_done = 1'b0; div_quot = '0; div_rem = '0;
        #12;
        check_eq("rst_hi", 64'(hi), 64'h0);
        check_eq("rst_lo", 64'(lo), 64'h0);
        check_eq("rst_stall", 64'(alu_stall), 64'h0);
        check_eq("rst_pulses", 64'({mul_start, div_start, div_cancel}), 64'h0);
        check_eq("rst_opnds", 64'({mul_a, div_b}), 64'h0);
        rst = 1'b1;
        cyc();

        // MULT -2 * 3 = -6
        run_op(OpMult, 32'hFFFF_FFFE, 32'd3, -1, st, ms, ds, cn, ck, sg);
        check_eq("mult_stall", 64'(st), 64'd4);
        check_eq("mult_starts", 64'(ms), 64'd1);
        check_eq("mult_sign", 64'(sg), 64'd1);
        check_eq("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check_eq("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        check_eq("mult_opnd_hold", 64'({mul_a, mul_b}), 64'hFFFF_FFFE_0000_0003);
        cyc();

        run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, st, ms, ds, cn, ck, sg);
        check_eq("multu_sign", 64'(sg), 64'd0);
        check_eq("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        cyc();

        // DIV -7 / 2 = -3 rem -1, divider answers 33 cycles after issue
        div_quot = 32'hFFFF_FFFD; div_rem = 32'hFFFF_FFFF;
        run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, 33, st, ms, ds, cn, ck, sg);
        check_eq("div_stall", 64'(st), 64'd34);
        check_eq("div_starts", 64'(ds), 64'd1);
        check_eq("div_no_cancel", 64'(cn), 64'd0);
        check_eq("div_sign", 64'(sg), 64'd1);
        check_eq("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        check_eq("div_opnd_hold", 64'({div_a, div_b}), 64'hFFFF_FFF9_0000_0002);
        cyc();

        run_op(OpDivu, 32'd7, 32'd0, -1, st, ms, ds, cn, ck, sg);
        check_eq("div0_stall", 64'(st), 64'd0);
        check_eq("div0_starts", 64'(ds), 64'd0);
        cyc();
        check_eq("div0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // DIV flushed on the 10th wait cycle; a late done must be ignored
        div_quot = 32'd5; div_rem = 32'd5;
        op = OpDiv; source_a = 32'd100; source_b = 32'd7;
        #1;
        check_eq("flush_div_start", 64'(div_start), 64'd1);
        acc = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k == 10) reg_flush = 1'b1;
            #1;
            if (div_cancel) acc++;
            if (k == 10) check_eq("flush_cancel", 64'(div_cancel), 64'd1);
        end
        check_eq("flush_cancel_cnt", 64'(acc), 64'd1);
        cyc();
        reg_flush = 1'b0; op = OpNone;
        #1;
        check_eq("flush_idle", 64'({alu_stall, div_cancel}), 64'h0);
        div_done = 1'b1;
        cyc();
        div_done = 1'b0;
        #1;
        check_eq("flush_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

        // MULT 5*6 issued and completed under a downstream hold
        reg_stall = 1'b1;
        run_op(OpMult, 32'd5, 32'd6, -1, st, ms, ds, cn, ck, sg);
        check_eq("stl_mult_stall", 64'(st), 64'd4);
        check_eq("stl_mult_hilo", {hi, lo}, 64'h0000_0000_0000_001E);
        op = OpMult;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (alu_stall || mul_start) acc++;
            ms += int'(mul_start);
        end
        check_eq("stl_done_quiet", 64'(acc), 64'd0);
        check_eq("stl_single_start", 64'(ms), 64'd1);
        op = OpNone; reg_stall = 1'b0;
        cyc();

        op = OpMtlo; source_a = 32'hA5A5_0001; reg_stall = 1'b1;
        #1;
        check_eq("mtlo_nostall", 64'(alu_stall), 64'd0);
        cyc();
        cyc();
        check_eq("mtlo_stalled", 64'(lo), 64'd30);
        reg_stall = 1'b0;
        cyc();
        check_eq("mtlo_write", 64'(lo), 64'hA5A5_0001);
        op = OpMthi; source_a = 32'h5A5A_0002; reg_flush = 1'b1;
        cyc();
        check_eq("mthi_flushed", 64'(hi), 64'h0);
        reg_flush = 1'b0;
        cyc();
        check_eq("mthi_write", 64'(hi), 64'h5A5A_0002);
        op = OpNone;
        cyc();

        // Divider never answers: watchdog cancel on the 41st cycle after issue (cnt 40 down to 0)
        run_op(OpDiv, 32'd1, 32'd1, -1, st, ms, ds, cn, ck, sg);
        check_eq("wdog_cancels", 64'(cn), 64'd1);
        check_eq("wdog_cancel_cyc", 64'(ck), 64'd41);
        check_eq("wdog_stall", 64'(st), 64'd42);
        check_eq("wdog_hilo", {hi, lo}, 64'h5A5A_0002_A5A5_0001);
        cyc();

        // Asynchronous reset in the middle of MUL_WAIT
        op = OpMult; source_a = 32'd2; source_b = 32'd3;
        cyc();
        op = OpNone;
        #2;
        rst = 1'b0;
        #1;
        check_eq("arst_hilo", {hi, lo}, 64'h0);
        check_eq("arst_idle", 64'({alu_stall, mul_a}), 64'h0);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        check_eq("arst_no_write", {hi, lo}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
